// File: rtl/i2c_apb_cmd_sched.sv
// Round-robin scheduler that shares one APB-attached I2C controller among NUM_REQ
// requesters, each issuing a single-byte read or write transfer.
module i2c_apb_cmd_sched #(
  parameter int         NUM_REQ  = 4,
  parameter logic [7:0] REG_ADDR = 8'h00,
  parameter logic [7:0] REG_TX   = 8'h04,
  parameter logic [7:0] REG_RX   = 8'h08,
  parameter logic [7:0] REG_CMD  = 8'h0C,
  parameter logic [7:0] REG_STAT = 8'h10,
  parameter int         POLL_MAX = 1024
) (
  input  logic                   pclk_i,
  input  logic                   preset_ni,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*7-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]     req_rw_i,
  input  logic [NUM_REQ*8-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [7:0]             rdata_o,
  output logic                   err_o,
  output logic [7:0]             paddr_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [7:0]             pwdata_o,
  input  logic [7:0]             prdata_i,
  input  logic                   pready_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0]      POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [IW-1:0]      IDX_LAST  = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_TX   = 3'd2,
    ST_WR_CMD  = 3'd3,
    ST_POLL    = 3'd4,
    ST_RD_RX   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   ptr_r;
  logic [6:0]      addr_r;
  logic            rw_r;
  logic [7:0]      wdata_r;
  logic [PW-1:0]   poll_cnt_r;

  logic [IW-1:0]   sel_idx_s;
  logic [IW-1:0]   cand_s;
  logic            sel_vld_s;
  logic [7:0]      acc_addr_s;
  logic            acc_write_s;
  logic [7:0]      acc_data_s;

  // First pending request at or above the pointer, wrapping around.
  always_comb begin
    sel_vld_s = 1'b0;
    sel_idx_s = '0;
    cand_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = IW'((int'(ptr_r) + k) % NUM_REQ);
      if (!sel_vld_s && req_i[cand_s]) begin
        sel_vld_s = 1'b1;
        sel_idx_s = cand_s;
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
  end

  // Address, direction and data presented by the access owned by the current state.
  always_comb begin
    acc_addr_s  = REG_STAT;
    acc_write_s = 1'b0;
    acc_data_s  = 8'h00;
    case (state_r)
      ST_WR_ADDR: begin
        acc_addr_s  = REG_ADDR;
        acc_write_s = 1'b1;
        acc_data_s  = {addr_r, rw_r};
      end
      ST_WR_TX: begin
        acc_addr_s  = REG_TX;
        acc_write_s = 1'b1;
        acc_data_s  = wdata_r;
      end
      ST_WR_CMD: begin
        acc_addr_s  = REG_CMD;
        acc_write_s = 1'b1;
        acc_data_s  = 8'h01;
      end
      ST_RD_RX: begin
        acc_addr_s  = REG_RX;
      end
      default: begin
        acc_addr_s  = REG_STAT;
      end
    endcase
  end

  // Scheduler FSM with the APB handshake; psel drops for one cycle after every access.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      addr_r     <= 7'h00;
      rw_r       <= 1'b0;
      wdata_r    <= 8'h00;
      poll_cnt_r <= '0;
      gnt_o      <= '0;
      done_o     <= '0;
      rdata_o    <= 8'h00;
      err_o      <= 1'b0;
      paddr_o    <= 8'h00;
      psel_o     <= 1'b0;
      penable_o  <= 1'b0;
      pwrite_o   <= 1'b0;
      pwdata_o   <= 8'h00;
    end else begin
      done_o <= '0;
      case (state_r)
        ST_IDLE: begin
          if (sel_vld_s) begin
            addr_r     <= req_addr_i[int'(sel_idx_s)*7 +: 7];
            rw_r       <= req_rw_i[sel_idx_s];
            wdata_r    <= req_wdata_i[int'(sel_idx_s)*8 +: 8];
            gnt_o      <= ONE_HOT0 << sel_idx_s;
            ptr_r      <= (sel_idx_s == IDX_LAST) ? '0 : sel_idx_s + IW'(1);
            poll_cnt_r <= '0;
            state_r    <= ST_WR_ADDR;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_WR_ADDR, ST_WR_TX, ST_WR_CMD, ST_POLL, ST_RD_RX: begin
          if (!psel_o) begin
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            paddr_o   <= acc_addr_s;
            pwrite_o  <= acc_write_s;
            pwdata_o  <= acc_data_s;
          end else if (!penable_o) begin
            penable_o <= 1'b1;
          end else if (pready_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            case (state_r)
              ST_WR_ADDR: state_r <= rw_r ? ST_WR_CMD : ST_WR_TX;
              ST_WR_TX:   state_r <= ST_WR_CMD;
              ST_WR_CMD:  state_r <= ST_POLL;
              ST_POLL: begin
                if (prdata_i[0]) begin
                  // Still busy: either poll again or give up with a timeout error.
                  if (poll_cnt_r == POLL_LAST) begin
                    done_o  <= gnt_o;
                    err_o   <= 1'b1;
                    rdata_o <= 8'h00;
                    state_r <= ST_DONE;
                  end else begin
                    poll_cnt_r <= poll_cnt_r + PW'(1);
                  end
                end else if (rw_r && !prdata_i[1]) begin
                  state_r <= ST_RD_RX;
                end else begin
                  done_o  <= gnt_o;
                  err_o   <= prdata_i[1];
                  rdata_o <= 8'h00;
                  state_r <= ST_DONE;
                end
              end
              ST_RD_RX: begin
                done_o  <= gnt_o;
                err_o   <= 1'b0;
                rdata_o <= prdata_i;
                state_r <= ST_DONE;
              end
              default: state_r <= ST_IDLE;
            endcase
          end else begin
            penable_o <= 1'b1;
          end
        end
        ST_DONE: begin
          gnt_o   <= '0;
          state_r <= ST_IDLE;
        end
        default: begin
          gnt_o   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_apb_cmd_sched.sv
// Directed bench: an APB slave model answers the controller registers while
// scoreboard queues hold the expected accesses, grants and completions.
module tb_i2c_apb_cmd_sched;

  localparam int NR = 4;
  localparam int POLL_MAX = 4;
  localparam logic [7:0] REG_ADDR = 8'h00;
  localparam logic [7:0] REG_TX   = 8'h04;
  localparam logic [7:0] REG_RX   = 8'h08;
  localparam logic [7:0] REG_CMD  = 8'h0C;
  localparam logic [7:0] REG_STAT = 8'h10;

  logic            pclk_i = 1'b0;
  logic            preset_ni;
  logic [NR-1:0]   req_i;
  logic [NR*7-1:0] req_addr_i;
  logic [NR-1:0]   req_rw_i;
  logic [NR*8-1:0] req_wdata_i;
  logic [NR-1:0]   gnt_o, done_o;
  logic [7:0]      rdata_o, paddr_o, pwdata_o, prdata_i;
  logic            err_o, psel_o, penable_o, pwrite_o, pready_i;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_acc_q[$];
  logic [12:0] exp_done_q[$];
  logic [3:0]  exp_gnt_q[$];
  logic [7:0]  stat_q[$];
  logic [7:0]  stat_default = 8'h00;
  logic [7:0]  rx_val = 8'h00;
  int          wait_states = 0;
  int          poll_seen = 0;

  i2c_apb_cmd_sched #(.NUM_REQ(NR), .POLL_MAX(POLL_MAX)) dut (
    .pclk_i(pclk_i), .preset_ni(preset_ni), .req_i(req_i), .req_addr_i(req_addr_i),
    .req_rw_i(req_rw_i), .req_wdata_i(req_wdata_i), .gnt_o(gnt_o), .done_o(done_o),
    .rdata_o(rdata_o), .err_o(err_o), .paddr_o(paddr_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Program requester idx and push every access, grant and completion it should cause.
  task automatic queue_txn(input int idx, input logic [6:0] a, input logic rw,
                           input logic [7:0] wd, input int busy, input logic [7:0] last,
                           input logic [7:0] rx, input bit stuck);
    logic [3:0] oh;
    logic [7:0] rd;
    logic       er;
    oh = 4'b0001 << idx;
    req_addr_i[idx*7 +: 7]  = a;
    req_rw_i[idx]           = rw;
    req_wdata_i[idx*8 +: 8] = wd;
    exp_gnt_q.push_back(oh);
    exp_acc_q.push_back({REG_ADDR, 1'b1, a, rw});
    if (!rw) exp_acc_q.push_back({REG_TX, 1'b1, wd});
    exp_acc_q.push_back({REG_CMD, 1'b1, 8'h01});
    rd = 8'h00;
    if (stuck) begin
      for (int i = 0; i < POLL_MAX; i++) exp_acc_q.push_back({REG_STAT, 1'b0, 8'h00});
      er = 1'b1;
    end else begin
      for (int i = 0; i < busy; i++) begin
        stat_q.push_back(8'h01);
        exp_acc_q.push_back({REG_STAT, 1'b0, 8'h00});
      end
      stat_q.push_back(last);
      exp_acc_q.push_back({REG_STAT, 1'b0, 8'h00});
      er = last[1];
      if (rw && !er) begin
        exp_acc_q.push_back({REG_RX, 1'b0, 8'h00});
        rd = rx;
        rx_val = rx;
      end
    end
    exp_done_q.push_back({oh, rd, er});
  endtask

  task automatic wait_done(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 3000) begin
      @(negedge pclk_i);
      cyc++;
      if (done_o != '0) seen++;
    end
    req_i = '0;
    chk("done_count", seen, n);
    chk("accesses_drained", exp_acc_q.size(), 0);
  endtask

  // APB slave: checks each access at SETUP, holds it stable through ACCESS, inserts wait states.
  logic [16:0] sl_hold;
  logic [16:0] sl_cur;
  logic [16:0] sl_e;
  logic        sl_prev_psel = 1'b0;
  int          sl_ws = 0;
  initial begin
    pready_i = 1'b0;
    prdata_i = 8'h00;
    forever begin
      @(negedge pclk_i);
      if (psel_o && !penable_o) begin
        chk("apb_idle_gap", sl_prev_psel, 1'b0);
        sl_cur  = {paddr_o, pwrite_o, pwrite_o ? pwdata_o : 8'h00};
        sl_hold = {paddr_o, pwrite_o, pwdata_o};
        if (paddr_o == REG_STAT) poll_seen++;
        checks++;
        assert (exp_acc_q.size() != 0) else begin
          errors++;
          $error("FAIL apb_extra_access: observed=%0h expected=none", sl_cur);
        end
        if (exp_acc_q.size() != 0) begin
          sl_e = exp_acc_q.pop_front();
          chk("apb_access", sl_cur, sl_e);
        end
        sl_ws    = 0;
        pready_i = 1'b0;
      end else if (psel_o && penable_o) begin
        chk("apb_stable", {paddr_o, pwrite_o, pwdata_o}, sl_hold);
        if (sl_ws < wait_states) begin
          sl_ws++;
          pready_i = 1'b0;
        end else begin
          pready_i = 1'b1;
          if (paddr_o == REG_STAT) prdata_i = (stat_q.size() != 0) ? stat_q.pop_front() : stat_default;
          else if (paddr_o == REG_RX) prdata_i = rx_val;
          else prdata_i = 8'h00;
        end
      end else begin
        pready_i = 1'b0;
        prdata_i = 8'h00;
      end
      sl_prev_psel = psel_o;
    end
  end

  // Grant and completion monitor.
  logic [12:0] mon_e;
  logic [3:0]  mon_g;
  logic [3:0]  prev_gnt = 4'b0000;
  initial begin
    forever begin
      @(negedge pclk_i);
      if (done_o != '0) begin
        checks++;
        assert (exp_done_q.size() != 0) else begin
          errors++;
          $error("FAIL done_extra: observed=%0h expected=none", done_o);
        end
        if (exp_done_q.size() != 0) begin
          mon_e = exp_done_q.pop_front();
          chk("done_rdata_err", {done_o, rdata_o, err_o}, mon_e);
          chk("gnt_at_done", gnt_o, mon_e[12:9]);
        end
      end
      if (gnt_o != '0 && prev_gnt == '0) begin
        checks++;
        assert (exp_gnt_q.size() != 0) else begin
          errors++;
          $error("FAIL grant_extra: observed=%0h expected=none", gnt_o);
        end
        if (exp_gnt_q.size() != 0) begin
          mon_g = exp_gnt_q.pop_front();
          chk("grant_order", gnt_o, mon_g);
        end
      end else if (gnt_o != '0) begin
        chk("gnt_held", gnt_o, prev_gnt);
      end
      prev_gnt = gnt_o;
    end
  end

  initial begin
    int cyc;
    preset_ni   = 1'b0;
    req_i       = '0;
    req_addr_i  = '0;
    req_rw_i    = '0;
    req_wdata_i = '0;
    repeat (3) @(negedge pclk_i);
    chk("reset_outputs", {gnt_o, done_o, rdata_o, err_o, paddr_o, psel_o, penable_o, pwrite_o, pwdata_o}, 64'd0);
    preset_ni = 1'b1;
    repeat (2) @(negedge pclk_i);

    // Round robin from pointer 0: 0,1,2,3,0.
    for (int i = 0; i < NR; i++) queue_txn(i, 7'h10 + 7'(i), 1'b0, 8'h30 + 8'(i), 0, 8'h00, 8'h00, 1'b0);
    queue_txn(0, 7'h10, 1'b0, 8'h30, 0, 8'h00, 8'h00, 1'b0);
    req_i = 4'b1111;
    wait_done(5);

    // Single write with two busy polls.
    queue_txn(0, 7'h50, 1'b0, 8'hA5, 2, 8'h00, 8'h00, 1'b0);
    req_i = 4'b0001;
    wait_done(1);

    // Single read; result must hold afterwards.
    queue_txn(2, 7'h3C, 1'b1, 8'h00, 0, 8'h00, 8'h5E, 1'b0);
    req_i = 4'b0100;
    wait_done(1);
    repeat (3) @(negedge pclk_i);
    chk("rdata_hold", {rdata_o, err_o}, {8'h5E, 1'b0});

    // NACK on a read, with the request withdrawn right after grant.
    queue_txn(3, 7'h22, 1'b1, 8'h00, 0, 8'h02, 8'hEE, 1'b0);
    req_i = 4'b1000;
    cyc = 0;
    while (gnt_o == '0 && cyc < 50) begin
      @(negedge pclk_i);
      cyc++;
    end
    chk("nack_granted", gnt_o, 4'b1000);
    req_i = '0;
    wait_done(1);

    // Three wait states on every access.
    wait_states = 3;
    queue_txn(1, 7'h11, 1'b0, 8'h5A, 1, 8'h00, 8'h00, 1'b0);
    req_i = 4'b0010;
    wait_done(1);
    wait_states = 0;

    // Status stuck busy: POLL_MAX polls then timeout error.
    stat_default = 8'h01;
    queue_txn(0, 7'h40, 1'b1, 8'h00, 0, 8'h00, 8'h99, 1'b1);
    req_i = 4'b0001;
    wait_done(1);

    // Reset in the middle of polling requester 1 (pointer would otherwise move to 2).
    queue_txn(1, 7'h2A, 1'b0, 8'hC3, 0, 8'h00, 8'h00, 1'b1);
    poll_seen = 0;
    req_i = 4'b0010;
    cyc = 0;
    while (poll_seen < 2 && cyc < 500) begin
      @(negedge pclk_i);
      cyc++;
    end
    chk("victim_in_poll", poll_seen >= 2, 1'b1);
    preset_ni = 1'b0;
    #1;
    chk("reset_mid_poll_outputs", {gnt_o, done_o, rdata_o, err_o, paddr_o, psel_o, penable_o, pwrite_o, pwdata_o}, 64'd0);
    req_i = '0;
    exp_acc_q.delete();
    exp_done_q.delete();
    exp_gnt_q.delete();
    stat_q.delete();
    stat_default = 8'h00;
    repeat (3) @(negedge pclk_i);
    preset_ni = 1'b1;
    repeat (2) @(negedge pclk_i);
    chk("no_done_after_abort", done_o, 4'b0000);

    // Pointer restarts at 0: requesters 0 and 3 pending, 0 wins.
    queue_txn(0, 7'h05, 1'b0, 8'h77, 0, 8'h00, 8'h00, 1'b0);
    req_addr_i[3*7 +: 7]  = 7'h06;
    req_wdata_i[3*8 +: 8] = 8'h66;
    req_rw_i[3]           = 1'b0;
    req_i = 4'b1001;
    wait_done(1);
    repeat (3) @(negedge pclk_i);
    chk("grants_drained", exp_gnt_q.size(), 0);
    chk("dones_drained", exp_done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
